// File: rtl/vslc_timer_bank_if.sv
// Shared config port plus per-channel start/stop levels and status outputs
// of the timer bank.
interface vslc_timer_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 10
);
    logic                cfg_we;
    logic [2:0]          cfg_chan;
    logic [1:0]          cfg_sel;
    logic [WIDTH-1:0]    cfg_data;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] stop;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] enabled;
    logic [CHANNELS-1:0] done;

    modport master (
        output cfg_we, cfg_chan, cfg_sel, cfg_data, start, stop,
        input  out, enabled, done
    );

    modport slave (
        input  cfg_we, cfg_chan, cfg_sel, cfg_data, start, stop,
        output out, enabled, done
    );
endinterface

// File: rtl/vslc_timer_bank.sv
// Bank of independent two-phase timers with per-channel prescaler, phase
// periods and cycle/one-shot mode, configured through one shared write port.
module vslc_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 10,
    parameter int DIV_BITS = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    vslc_timer_bank_if.slave   bus
);
    localparam int PRE_W = (1 << DIV_BITS) - 1;

    logic [CHANNELS-1:0][WIDTH-1:0]    period_a_q, period_a_d;
    logic [CHANNELS-1:0][WIDTH-1:0]    period_b_q, period_b_d;
    logic [CHANNELS-1:0][DIV_BITS-1:0] div_q, div_d;
    logic [CHANNELS-1:0]               mode_q, mode_d;
    logic [CHANNELS-1:0][PRE_W-1:0]    pre_q, pre_d;
    logic [CHANNELS-1:0][WIDTH-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0]               phase_q, phase_d;
    logic [CHANNELS-1:0]               out_q, out_d;
    logic [CHANNELS-1:0]               enabled_q, enabled_d;
    logic [CHANNELS-1:0]               done_q, done_d;
    logic [CHANNELS-1:0]               start_prev_q, stop_prev_q;
    logic [CHANNELS-1:0]               st, sp;

    // Terminal prescaler value 2^d-1; a live div change compares with >=.
    function automatic logic [PRE_W-1:0] term_of(input logic [DIV_BITS-1:0] d);
        logic [PRE_W:0] one_hot;
        one_hot    = '0;
        one_hot[d] = 1'b1;
        term_of    = PRE_W'(one_hot - (PRE_W+1)'(1));
    endfunction

    assign st = bus.start & ~start_prev_q;
    assign sp = bus.stop  & ~stop_prev_q;

    always_comb begin
        period_a_d = period_a_q;
        period_b_d = period_b_q;
        div_d      = div_q;
        mode_d     = mode_q;
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        out_d      = out_q;
        enabled_d  = enabled_q;
        done_d     = '0;

        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.cfg_we && (bus.cfg_chan == 3'(c))) begin
                case (bus.cfg_sel)
                    2'd0:    period_a_d[c] = bus.cfg_data;
                    2'd1:    period_b_d[c] = bus.cfg_data;
                    2'd2:    div_d[c]      = bus.cfg_data[DIV_BITS-1:0];
                    default: mode_d[c]     = bus.cfg_data[0];
                endcase
            end

            if (sp[c]) begin
                enabled_d[c] = 1'b0;
                out_d[c]     = 1'b0;
                pre_d[c]     = '0;
                cnt_d[c]     = '0;
                phase_d[c]   = 1'b0;
            end else if (st[c]) begin
                enabled_d[c] = 1'b1;
                out_d[c]     = 1'b1;
                pre_d[c]     = '0;
                cnt_d[c]     = '0;
                phase_d[c]   = 1'b0;
            end else if (enabled_q[c]) begin
                if (pre_q[c] >= term_of(div_q[c])) begin
                    pre_d[c] = '0;
                    if (!phase_q[c]) begin
                        if (cnt_q[c] >= period_a_q[c]) begin
                            cnt_d[c] = '0;
                            out_d[c] = 1'b0;
                            if (mode_q[c]) begin
                                enabled_d[c] = 1'b0;
                                done_d[c]    = 1'b1;
                            end else begin
                                phase_d[c] = 1'b1;
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] + WIDTH'(1);
                        end
                    end else begin
                        if (cnt_q[c] >= period_b_q[c]) begin
                            phase_d[c] = 1'b0;
                            cnt_d[c]   = '0;
                            out_d[c]   = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + WIDTH'(1);
                        end
                    end
                end else begin
                    pre_d[c] = pre_q[c] + PRE_W'(1);
                end
            end
        end
    end

    // Edge-detect history resets high so levels held through reset stay quiet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_a_q   <= {CHANNELS{WIDTH'(2)}};
            period_b_q   <= {CHANNELS{WIDTH'(3)}};
            div_q        <= '0;
            mode_q       <= '0;
            pre_q        <= '0;
            cnt_q        <= '0;
            phase_q      <= '0;
            out_q        <= '0;
            enabled_q    <= '0;
            done_q       <= '0;
            start_prev_q <= '1;
            stop_prev_q  <= '1;
        end else begin
            period_a_q   <= period_a_d;
            period_b_q   <= period_b_d;
            div_q        <= div_d;
            mode_q       <= mode_d;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            out_q        <= out_d;
            enabled_q    <= enabled_d;
            done_q       <= done_d;
            start_prev_q <= bus.start;
            stop_prev_q  <= bus.stop;
        end
    end

    assign bus.out     = out_q;
    assign bus.enabled = enabled_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_vslc_timer_bank.sv
// Directed bench for vslc_timer_bank: vector table for reset/edge behaviour,
// hand sequences for prescaler, stop/restart, live config and independence.
module tb_vslc_timer_bank;
    localparam int CH = 4;
    localparam int W  = 10;

    typedef struct {
        logic          rst;
        logic [CH-1:0] start;
        logic [CH-1:0] stop;
        logic [CH-1:0] e_out;
        logic [CH-1:0] e_en;
        logic [CH-1:0] e_done;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    vslc_timer_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    vslc_timer_bank #(.CHANNELS(CH), .WIDTH(W), .DIV_BITS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_cfg(input int ch, input int sel, input int data);
        bus.cfg_we   = 1'b1;
        bus.cfg_chan = 3'(ch);
        bus.cfg_sel  = 2'(sel);
        bus.cfg_data = W'(data);
        cyc();
        bus.cfg_we   = 1'b0;
    endtask

    initial begin
        vec_t vecs[22];
        int pa[CH];
        int pb[CH];
        int dv[CH];
        logic [CH-1:0] exp_out;

        tests  = 0;
        failed = 0;
        rst          = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_chan = '0;
        bus.cfg_sel  = '0;
        bus.cfg_data = '0;
        bus.start    = '0;
        bus.stop     = '0;

        // rst, start, stop -> out, enabled, done (sampled after the edge)
        vecs[0]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[5]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        vecs[6]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        vecs[7]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        vecs[8]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vecs[9]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vecs[10] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vecs[11] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vecs[12] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        vecs[13] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        vecs[14] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        vecs[15] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vecs[16] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vecs[17] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[18] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[20] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[21] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        for (int i = 0; i < 22; i++) begin
            rst       = vecs[i].rst;
            bus.start = vecs[i].start;
            bus.stop  = vecs[i].stop;
            cyc();
            chk($sformatf("vec%0d_out", i),  32'(bus.out),     32'(vecs[i].e_out));
            chk($sformatf("vec%0d_en", i),   32'(bus.enabled), 32'(vecs[i].e_en));
            chk($sformatf("vec%0d_done", i), 32'(bus.done),    32'(vecs[i].e_done));
        end

        // ch1 one-shot, div=2, period_a=1: 8 cycles high then a done pulse
        set_cfg(1, 2, 2);
        set_cfg(1, 0, 1);
        set_cfg(1, 3, 1);
        bus.start = 4'b0010;
        cyc();
        chk("os_first_out", 32'(bus.out[1]), 32'd1);
        chk("os_first_en", 32'(bus.enabled[1]), 32'd1);
        for (int k = 1; k < 8; k++) begin
            cyc();
            chk($sformatf("os_high%0d", k), 32'(bus.out[1]), 32'd1);
            chk($sformatf("os_nodone%0d", k), 32'(bus.done[1]), 32'd0);
        end
        cyc();
        chk("os_end_out", 32'(bus.out[1]), 32'd0);
        chk("os_end_en", 32'(bus.enabled[1]), 32'd0);
        chk("os_end_done", 32'(bus.done), 32'b0010);
        cyc();
        chk("os_done_single", 32'(bus.done), 32'd0);

        // ch0 stop mid phase A, then a fresh 6-cycle phase A
        set_cfg(0, 0, 5);
        bus.start = 4'b0011;
        cyc();
        chk("sr_run_out", 32'(bus.out[0]), 32'd1);
        cyc();
        cyc();
        bus.stop = 4'b0001;
        cyc();
        chk("sr_stop_out", 32'(bus.out[0]), 32'd0);
        chk("sr_stop_en", 32'(bus.enabled[0]), 32'd0);
        chk("sr_stop_done", 32'(bus.done), 32'd0);
        cyc();
        chk("sr_idle_done", 32'(bus.done), 32'd0);
        chk("sr_idle_en", 32'(bus.enabled[0]), 32'd0);
        bus.start = 4'b0010;
        bus.stop  = 4'b0000;
        cyc();
        bus.start = 4'b0011;
        cyc();
        chk("sr_restart_out", 32'(bus.out[0]), 32'd1);
        for (int k = 1; k < 6; k++) begin
            cyc();
            chk($sformatf("sr_high%0d", k), 32'(bus.out[0]), 32'd1);
        end
        cyc();
        chk("sr_phase_b_out", 32'(bus.out[0]), 32'd0);
        chk("sr_phase_b_en", 32'(bus.enabled[0]), 32'd1);
        bus.stop = 4'b0001;
        cyc();
        chk("sr_final_stop", 32'(bus.enabled[0]), 32'd0);
        bus.stop = 4'b0000;

        // ch2 period_b 9 lowered to 0 live while cnt=5 in phase B
        set_cfg(2, 1, 9);
        bus.start = 4'b0111;
        cyc();
        chk("pb_start_out", 32'(bus.out[2]), 32'd1);
        repeat (8) cyc();
        chk("pb_in_b", 32'(bus.out[2]), 32'd0);
        bus.cfg_we   = 1'b1;
        bus.cfg_chan = 3'd2;
        bus.cfg_sel  = 2'd1;
        bus.cfg_data = '0;
        cyc();
        bus.cfg_we = 1'b0;
        chk("pb_write_tick_old", 32'(bus.out[2]), 32'd0);
        cyc();
        chk("pb_end_next_tick", 32'(bus.out[2]), 32'd1);
        cyc();
        chk("pb_a2", 32'(bus.out[2]), 32'd1);
        cyc();
        chk("pb_a3", 32'(bus.out[2]), 32'd1);
        cyc();
        chk("pb_short_b", 32'(bus.out[2]), 32'd0);
        cyc();
        chk("pb_back_a", 32'(bus.out[2]), 32'd1);
        bus.stop = 4'b0100;
        cyc();
        chk("pb_stop_en", 32'(bus.enabled[2]), 32'd0);
        bus.stop = 4'b0000;

        // all channels with distinct timing, plus ignored out-of-range writes
        pa = '{1, 3, 2, 0};
        pb = '{2, 1, 0, 1};
        dv = '{0, 0, 0, 1};
        set_cfg(0, 0, 1);
        set_cfg(0, 1, 2);
        set_cfg(1, 3, 0);
        set_cfg(1, 2, 0);
        set_cfg(1, 0, 3);
        set_cfg(1, 1, 1);
        set_cfg(3, 2, 1);
        set_cfg(3, 0, 0);
        set_cfg(3, 1, 1);
        set_cfg(4, 0, 0);
        set_cfg(5, 1, 0);
        set_cfg(6, 2, 9);
        set_cfg(7, 3, 1);
        bus.start = 4'b0000;
        cyc();
        bus.start = 4'b1111;
        for (int k = 0; k < 100; k++) begin
            if (k >= 20 && k < 24) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_chan = 3'(4 + k - 20);
                bus.cfg_sel  = 2'(k - 20);
                bus.cfg_data = W'(k - 20);
            end else begin
                bus.cfg_we = 1'b0;
            end
            cyc();
            for (int c = 0; c < CH; c++) begin
                int per;
                int hi;
                per = (pa[c] + pb[c] + 2) << dv[c];
                hi  = (pa[c] + 1) << dv[c];
                exp_out[c] = ((k % per) < hi);
            end
            chk($sformatf("ind_k%0d", k), 32'(bus.out), 32'(exp_out));
        end
        chk("ind_all_en", 32'(bus.enabled), 32'hF);

        // reset mid-run clears everything and restores default periods
        rst = 1'b1;
        cyc();
        chk("rst_mid_out", 32'(bus.out), 32'd0);
        chk("rst_mid_en", 32'(bus.enabled), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        bus.start = 4'b0000;
        cyc();
        bus.start = 4'b0001;
        cyc();
        cyc();
        cyc();
        chk("rst_default_a_hi", 32'(bus.out[0]), 32'd1);
        cyc();
        chk("rst_default_a_end", 32'(bus.out[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/vslc_timer_bank.md
# vslc_timer_bank

Parametrised bank of independent two-phase timers, the next generation of the VSLC's single-channel timer. Each channel has its own prescaler, per-phase periods, and a cycle or one-shot mode. Channels are configured through a shared write port and started or stopped by edge-detected level inputs driven from the VSLC core's set/reset logic. Each channel's output feeds a `uo_out` bit, and its `enabled` status is read back as an input register.

## Interface

Parameters:
- `CHANNELS`, 4: number of timer channels (1..8).
- `WIDTH`, 10: period and phase-counter width, in bits.
- `DIV_BITS`, 4: divisor field width. Divisor `d` ranges 0..2^DIV_BITS-1, so the prescaler is 2^DIV_BITS-1 bits wide.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `cfg_we`  in  1  Config write strobe, one cycle.
- `cfg_chan`  in  3  Target channel. Writes to channels >= CHANNELS are ignored.
- `cfg_sel`  in  2  Field select: 0 = period_a, 1 = period_b, 2 = divisor (low DIV_BITS bits), 3 = mode (bit 0: 0 = cycle, 1 = one-shot).
- `cfg_data`  in  WIDTH  Write data.
- `start`  in  CHANNELS  Per-channel level; a rising edge starts or restarts the channel.
- `stop`  in  CHANNELS  Per-channel level; a rising edge stops the channel.
- `out`  out  CHANNELS  Timer output, registered.
- `enabled`  out  CHANNELS  Channel is running, registered.
- `done`  out  CHANNELS  One-cycle pulse when a one-shot completes.

## Operation

- Per-channel state:
  - config: `period_a`, `period_b`, `div`, `mode`
  - counters: `pre` (prescaler), `cnt` (WIDTH bits)
  - `phase` (0 = A, 1 = B)
  - `out`, `enabled`, `done`
  - `start_prev`, `stop_prev`
- Edge detection:
  - `st = start & ~start_prev`
  - `sp = stop & ~stop_prev`
  - The `_prev` registers update every cycle.
- Priority each cycle, per channel:
  1. `rst`.
  2. `sp`: `enabled`=0, `out`=0, counters and phase cleared, no `done`.
  3. `st`: `enabled`=1, `phase`=A, `cnt`=0, `pre`=0, `out`=1. Applies whether idle or running (restart).
  4. Running tick, described below.
- Tick: while enabled, `pre` increments each cycle. When `pre` == 2^div-1, `pre`←0 and a tick occurs. div=0 ticks every cycle.
- On a tick in phase A:
  - If `cnt` >= `period_a`, phase A ends:
    - cycle mode: `phase`←B, `cnt`←0, `out`←0.
    - one-shot mode: `enabled`←0, `out`←0, `done`←1, counters cleared.
  - Otherwise `cnt`←`cnt`+1.
- On a tick in phase B:
  - If `cnt` >= `period_b`: `phase`←A, `cnt`←0, `out`←1.
  - Otherwise `cnt`←`cnt`+1.
- Comparisons use >=, so lowering a period below the live count ends the phase on the next tick. `cnt` never wraps.
- Idle channel: `pre`, `cnt` and `phase` are held at 0, and `out` is 0.
- `done` is 1 only in the cycle after completion and is 0 otherwise.
- Config writes:
  - Take effect in the cycle after `cfg_we`.
  - Apply live to a running channel.
  - A `mode` change mid-run is evaluated at the next phase-A end.
  - A `div` change mid-run keeps `pre`; the >= rule applies (`pre` >= 2^div-1 ticks).

## Timing

- Reset values:
  - `out`=0, `enabled`=0, `done`=0.
  - `period_a`=2, `period_b`=3, `div`=0, `mode`=cycle.
  - `start_prev` and `stop_prev` all-ones, so a level held high through reset does not trigger.
- Latency: a start edge sampled at edge t gives `enabled`=`out`=1 from t+1.
- Phase durations:
  - Phase A lasts exactly (period_a+1)·2^div cycles.
  - Phase B lasts exactly (period_b+1)·2^div cycles.
  - Cycle mode: period (period_a+period_b+2)·2^div, `out` high in phase A.
- One-shot: `out` high for (period_a+1)·2^div cycles. `done` pulses in the same cycle that `out` and `enabled` fall.
- Simultaneous events:
  - `st` and `sp` in the same cycle: stop wins.
  - A start edge in the same cycle as a phase end: restart wins.
  - A config write in the same cycle as a tick: the tick uses the old value.
- Reset mid-run clears everything within one cycle and emits no `done` pulse.
- Channels are fully independent; no shared state except the config port.

## Test plan

- **Reset:** hold `start`=1 across reset release, defaults loaded. Expect no start: `enabled`=0, `out`=0. Toggle `start` 0→1, then `out`=1 for 3 cycles, 0 for 4 cycles, repeating.
- **Prescaler, one-shot:** ch1 `div`=2, `period_a`=1, mode one-shot, start edge. Expect `out` high exactly 8 cycles, then `enabled`=0 and a single `done` pulse coincident with `out` falling.
- **Stop and restart:** ch0 running with `period_a`=5; stop edge at cycle 3 of phase A. Expect `out`=0 and `enabled`=0 next cycle, no `done`. Start again: a fresh 6-cycle high phase.
- **Simultaneous edges and live config:** start and stop edges together, expect the channel to stay idle. While running with `period_b`=9, write `period_b`=0 when `cnt`=5: phase B ends on the next tick.
- **Independence and bad write:** all CHANNELS running with different periods. Writes to a channel >= CHANNELS change nothing. Each channel's `out` waveform matches its formula over 100 cycles.
